reg_file_sb: RTL and testbench

//   Parametrised 2-read / 1-write register file for the pipelined RISC-V core.

---
 rtl/reg_file_sb.sv | 107 ++++++++++
 tb/tb_reg_file_sb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb -- 2-read / 1-write register file with a per-register busy
// scoreboard for the pipelined RISC-V core. ID reads operands and hazard
// status here in one cycle. WB writes results and retires producers.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   A1/A2 -> RD1/RD2  combinational read ports (optional write-through bypass)
//   A3, WD, We      write port; We also clears busy[A3]
//   iss_v, iss_rd   issue strobe, marks iss_rd busy (set beats clear)
//   busy1/busy2     busy[A1]/busy[A2], registered state only (never bypassed)
//   busy_any        OR of all busy bits (pipeline drain indicator)

// One register plus its scoreboard bit. HARD_ZERO ties both to their reset
// value, so the flops fold away for the hardwired-zero register.
module reg_file_sb_cell #(
   parameter int DW        = 32,
   parameter bit HARD_ZERO = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [DW-1:0] wd,
   input  logic          set,
   input  logic          clr,
   output logic [DW-1:0] q,
   output logic          busy
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q    <= '0;
         busy <= 1'b0;
      end else begin
         if (we && !HARD_ZERO) q <= wd;
         // A new producer issued in the same cycle the old one retires keeps
         // the register pending.
         if (set && !HARD_ZERO) busy <= 1'b1;
         else if (clr)          busy <= 1'b0;
      end
   end
endmodule

module reg_file_sb #(
   parameter  int DW       = 32,
   parameter  int NREGS    = 32,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] A1,
   input  logic [AW-1:0] A2,
   output logic [DW-1:0] RD1,
   output logic [DW-1:0] RD2,
   input  logic [AW-1:0] A3,
   input  logic [DW-1:0] WD,
   input  logic          We,
   input  logic          iss_v,
   input  logic [AW-1:0] iss_rd,
   output logic          busy1,
   output logic          busy2,
   output logic          busy_any
);
   localparam bit ZR = (ZERO_REG != 0);
   localparam bit BP = (BYPASS != 0);

   logic [NREGS-1:0][DW-1:0] regs;
   logic [NREGS-1:0]         busy;

   for (genvar r = 0; r < NREGS; r++) begin : g_reg
      localparam logic [AW-1:0] IDX = AW'(r);
      reg_file_sb_cell #(
         .DW        (DW),
         .HARD_ZERO (ZR && (r == 0))
      ) u_cell (
         .clk  (clk),
         .rst  (rst),
         .we   (We && (A3 == IDX)),
         .wd   (WD),
         .set  (iss_v && (iss_rd == IDX)),
         .clr  (We && (A3 == IDX)),
         .q    (regs[r]),
         .busy (busy[r])
      );
   end

   // Forwarding is gated by rst so the read ports stay at zero in reset even
   // while a write is presented.
   logic fwd_ok;
   assign fwd_ok = BP && We && !rst && !(ZR && (A3 == '0));

   always_comb begin
      RD1 = regs[A1];
      RD2 = regs[A2];
      if (fwd_ok && (A1 == A3)) RD1 = WD;
      if (fwd_ok && (A2 == A3)) RD2 = WD;
      if (rst) begin
         RD1 = '0;
         RD2 = '0;
      end
   end

   // Busy bits are cleared asynchronously, so these are already 0 in reset.
   assign busy1    = busy[A1];
   assign busy2    = busy[A2];
   assign busy_any = |busy;
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Shared stimulus for the two 32x32 instances (bypass on / off)
   logic [4:0]  A1, A2, A3, iss_rd;
   logic [31:0] WD;
   logic        We, iss_v;
   logic [31:0] rd1, rd2, nrd1, nrd2;
   logic        b1, b2, bany, nb1, nb2, nbany;

   // 16 x 64 instance
   logic [3:0]  pA1, pA2, pA3, p_iss_rd;
   logic [63:0] pWD, prd1, prd2;
   logic        pWe, p_iss_v, pb1, pb2, pbany;

   int n_cmp = 0;
   int n_err = 0;

   reg_file_sb #(.DW(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) u_dut (
      .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(rd1), .RD2(rd2),
      .A3(A3), .WD(WD), .We(We), .iss_v(iss_v), .iss_rd(iss_rd),
      .busy1(b1), .busy2(b2), .busy_any(bany));

   reg_file_sb #(.DW(32), .NREGS(32), .ZERO_REG(1), .BYPASS(0)) u_nb (
      .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(nrd1), .RD2(nrd2),
      .A3(A3), .WD(WD), .We(We), .iss_v(iss_v), .iss_rd(iss_rd),
      .busy1(nb1), .busy2(nb2), .busy_any(nbany));

   reg_file_sb #(.DW(64), .NREGS(16), .ZERO_REG(1), .BYPASS(1)) u_p (
      .clk(clk), .rst(rst), .A1(pA1), .A2(pA2), .RD1(prd1), .RD2(prd2),
      .A3(pA3), .WD(pWD), .We(pWe), .iss_v(p_iss_v), .iss_rd(p_iss_rd),
      .busy1(pb1), .busy2(pb2), .busy_any(pbany));

   task automatic test_reset();
      // in reset from time 0, with a write presented to reg5
      @(negedge clk);
      We = 1'b1; A3 = 5'd5; WD = 32'h1234_5678; A1 = 5'd5; A2 = 5'd5;
      #1;
      n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL rst_rd1_hold got=%h exp=%h", rd1, 32'h0); end
      n_cmp++; if (bany !== 1'b0) begin n_err++; $display("FAIL rst_bany_hold got=%b exp=0", bany); end
      @(negedge clk);
      rst = 1'b0; We = 1'b0;
      #1;
      n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL rst_write_ignored got=%h exp=%h", rd1, 32'h0); end
      // write reg5 and issue reg3, then assert reset mid-cycle
      @(negedge clk);
      We = 1'b1; A3 = 5'd5; WD = 32'hDEAD_BEEF; iss_v = 1'b1; iss_rd = 5'd3;
      @(negedge clk);
      We = 1'b0; iss_v = 1'b0;
      #1;
      n_cmp++; if (rd1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pre_rst_rd1 got=%h exp=%h", rd1, 32'hDEAD_BEEF); end
      n_cmp++; if (bany !== 1'b1) begin n_err++; $display("FAIL pre_rst_bany got=%b exp=1", bany); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL async_rst_rd1 got=%h exp=%h", rd1, 32'h0); end
      n_cmp++; if (bany !== 1'b0) begin n_err++; $display("FAIL async_rst_bany got=%b exp=0", bany); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL post_rst_rd1 got=%h exp=%h", rd1, 32'h0); end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      We = 1'b1; A3 = 5'd0; WD = 32'hFFFF_FFFF; A1 = 5'd0; A2 = 5'd0;
      #1;
      n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL zero_rd1_during got=%h exp=%h", rd1, 32'h0); end
      n_cmp++; if (nrd2 !== 32'h0) begin n_err++; $display("FAIL zero_nb_rd2_during got=%h exp=%h", nrd2, 32'h0); end
      @(negedge clk);
      We = 1'b0; iss_v = 1'b1; iss_rd = 5'd0;
      #1;
      n_cmp++; if (rd1 !== 32'h0) begin n_err++; $display("FAIL zero_rd1_after got=%h exp=%h", rd1, 32'h0); end
      @(negedge clk);
      iss_v = 1'b0;
      #1;
      n_cmp++; if (bany !== 1'b0) begin n_err++; $display("FAIL zero_issue_bany got=%b exp=0", bany); end
      n_cmp++; if (b1 !== 1'b0) begin n_err++; $display("FAIL zero_issue_busy1 got=%b exp=0", b1); end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      We = 1'b1; A3 = 5'd7; WD = 32'h11;
      @(negedge clk);
      WD = 32'h22; A1 = 5'd7; A2 = 5'd7;
      #1;
      n_cmp++; if (rd1 !== 32'h22) begin n_err++; $display("FAIL byp_rd1 got=%h exp=%h", rd1, 32'h22); end
      n_cmp++; if (rd2 !== 32'h22) begin n_err++; $display("FAIL byp_rd2 got=%h exp=%h", rd2, 32'h22); end
      n_cmp++; if (nrd1 !== 32'h11) begin n_err++; $display("FAIL nobyp_rd1_before got=%h exp=%h", nrd1, 32'h11); end
      n_cmp++; if (nrd2 !== 32'h11) begin n_err++; $display("FAIL nobyp_rd2_before got=%h exp=%h", nrd2, 32'h11); end
      @(negedge clk);
      We = 1'b0;
      #1;
      n_cmp++; if (nrd1 !== 32'h22) begin n_err++; $display("FAIL nobyp_rd1_after got=%h exp=%h", nrd1, 32'h22); end
      n_cmp++; if (rd1 !== 32'h22) begin n_err++; $display("FAIL byp_rd1_after got=%h exp=%h", rd1, 32'h22); end
      // per-port independence: only port 1 matches the write address
      @(negedge clk);
      We = 1'b1; A3 = 5'd7; WD = 32'h33; A1 = 5'd7; A2 = 5'd8;
      #1;
      n_cmp++; if (rd1 !== 32'h33) begin n_err++; $display("FAIL byp_port1_only got=%h exp=%h", rd1, 32'h33); end
      n_cmp++; if (rd2 !== 32'h0) begin n_err++; $display("FAIL byp_port2_old got=%h exp=%h", rd2, 32'h0); end
      @(negedge clk);
      We = 1'b0;
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      iss_v = 1'b1; iss_rd = 5'd9; A1 = 5'd9; A2 = 5'd10;
      #1;
      n_cmp++; if (b1 !== 1'b0) begin n_err++; $display("FAIL sb_busy1_same_cycle got=%b exp=0", b1); end
      @(negedge clk);
      iss_v = 1'b0;
      #1;
      n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL sb_busy1_set got=%b exp=1", b1); end
      n_cmp++; if (b2 !== 1'b0) begin n_err++; $display("FAIL sb_busy2_other got=%b exp=0", b2); end
      n_cmp++; if (bany !== 1'b1) begin n_err++; $display("FAIL sb_bany_set got=%b exp=1", bany); end
      n_cmp++; if (nb1 !== 1'b1) begin n_err++; $display("FAIL sb_nb_busy1_set got=%b exp=1", nb1); end
      // re-issue while busy, then one clear retires it (no count)
      @(negedge clk);
      iss_v = 1'b1;
      @(negedge clk);
      iss_v = 1'b0; We = 1'b1; A3 = 5'd9; WD = 32'h99;
      #1;
      n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL sb_clear_not_bypassed got=%b exp=1", b1); end
      @(negedge clk);
      We = 1'b0;
      #1;
      n_cmp++; if (b1 !== 1'b0) begin n_err++; $display("FAIL sb_busy1_clear got=%b exp=0", b1); end
      n_cmp++; if (bany !== 1'b0) begin n_err++; $display("FAIL sb_bany_clear got=%b exp=0", bany); end
      n_cmp++; if (nbany !== 1'b0) begin n_err++; $display("FAIL sb_nb_bany_clear got=%b exp=0", nbany); end
      n_cmp++; if (nb2 !== 1'b0) begin n_err++; $display("FAIL sb_nb_busy2 got=%b exp=0", nb2); end
   endtask

   task automatic test_set_clear_same();
      @(negedge clk);
      iss_v = 1'b1; iss_rd = 5'd4; A1 = 5'd4;
      @(negedge clk);
      We = 1'b1; A3 = 5'd4; WD = 32'hA5A5_5A5A;
      @(negedge clk);
      iss_v = 1'b0; We = 1'b0;
      #1;
      n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL setclr_busy4 got=%b exp=1", b1); end
      n_cmp++; if (rd1 !== 32'hA5A5_5A5A) begin n_err++; $display("FAIL setclr_reg4 got=%h exp=%h", rd1, 32'hA5A5_5A5A); end
      @(negedge clk);
      We = 1'b1; WD = 32'h0;
      @(negedge clk);
      We = 1'b0;
      #1;
      n_cmp++; if (b1 !== 1'b0) begin n_err++; $display("FAIL setclr_final_clear got=%b exp=0", b1); end
   endtask

   task automatic test_params();
      logic [63:0] e1, e2;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         pWe = 1'b1; pA3 = 4'(i); pWD = 64'hA5A5_0000_0000_0000 | 64'(i);
      end
      @(negedge clk);
      pWe = 1'b0;
      for (int i = 0; i < 16; i++) begin
         pA1 = 4'(i); pA2 = 4'(15 - i);
         e1 = (i == 0) ? 64'h0 : (64'hA5A5_0000_0000_0000 | 64'(i));
         e2 = (i == 15) ? 64'h0 : (64'hA5A5_0000_0000_0000 | 64'(15 - i));
         #1;
         n_cmp++; if (prd1 !== e1) begin n_err++; $display("FAIL p_rd1[%0d] got=%h exp=%h", i, prd1, e1); end
         n_cmp++; if (prd2 !== e2) begin n_err++; $display("FAIL p_rd2[%0d] got=%h exp=%h", i, prd2, e2); end
      end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         p_iss_v = 1'b1; p_iss_rd = 4'(i);
      end
      @(negedge clk);
      p_iss_v = 1'b0; pA1 = 4'd0; pA2 = 4'd15;
      #1;
      n_cmp++; if (pbany !== 1'b1) begin n_err++; $display("FAIL p_bany_all_set got=%b exp=1", pbany); end
      n_cmp++; if (pb1 !== 1'b0) begin n_err++; $display("FAIL p_busy_reg0 got=%b exp=0", pb1); end
      n_cmp++; if (pb2 !== 1'b1) begin n_err++; $display("FAIL p_busy_reg15 got=%b exp=1", pb2); end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         pWe = 1'b1; pA3 = 4'(i); pWD = 64'h0;
      end
      @(negedge clk);
      pWe = 1'b0;
      #1;
      n_cmp++; if (pbany !== 1'b0) begin n_err++; $display("FAIL p_bany_all_clear got=%b exp=0", pbany); end
   endtask

   initial begin
      rst = 1'b1;
      A1 = '0; A2 = '0; A3 = '0; WD = '0; We = 1'b0; iss_v = 1'b0; iss_rd = '0;
      pA1 = '0; pA2 = '0; pA3 = '0; pWD = '0; pWe = 1'b0; p_iss_v = 1'b0; p_iss_rd = '0;
      test_reset();
      test_zero_reg();
      test_bypass();
      test_scoreboard();
      test_set_clear_same();
      test_params();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
